// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-select adder family.
package csa_pkg;

    localparam int unsigned CSA_WIDTH = 32;
    localparam int unsigned CSA_BLOCK = 4;

    // Number of carry-select blocks; a zero block size yields zero blocks.
    function automatic int unsigned csa_num_blocks(input int unsigned width,
                                                   input int unsigned block);
        return (block == 0) ? 0 : width / block;
    endfunction

endpackage

// File: rtl/rca_block.sv
// BLOCK-bit ripple-carry adder used as the building block of csa_adder3.
module rca_block
    import csa_pkg::*;
#(
    parameter int unsigned BLOCK = CSA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < BLOCK; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[BLOCK];

endmodule

// File: rtl/csa_adder3.sv
// Carry-select adder: {Cout,S} = A + B + Cin. Define CSA_ADDER3_OUTREG_EN to
// add a one-cycle output register with synchronous active-high reset.
module csa_adder3
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = CSA_WIDTH,
    parameter int unsigned BLOCK = CSA_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int unsigned NBLK = csa_num_blocks(WIDTH, BLOCK);

    if (BLOCK == 0) begin : g_chk_block
        $fatal(1, "csa_adder3: BLOCK must be non-zero");
    end else if ((WIDTH % BLOCK) != 0) begin : g_chk_width
        $fatal(1, "csa_adder3: WIDTH must be a multiple of BLOCK");
    end

    logic [WIDTH-1:0] w_sum;
    logic [NBLK:0]    w_carry;

    assign w_carry[0] = Cin;

    // Block 0 ripples with Cin; upper blocks precompute both carry-in cases.
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_ripple
            rca_block #(.BLOCK(BLOCK)) u_rca (
                .a    (A[BLOCK-1:0]),
                .b    (B[BLOCK-1:0]),
                .cin  (w_carry[0]),
                .s    (w_sum[BLOCK-1:0]),
                .cout (w_carry[1])
            );
        end else begin : g_select
            logic [BLOCK-1:0] w_s0;
            logic [BLOCK-1:0] w_s1;
            logic             w_c0;
            logic             w_c1;

            rca_block #(.BLOCK(BLOCK)) u_rca0 (
                .a    (A[k*BLOCK +: BLOCK]),
                .b    (B[k*BLOCK +: BLOCK]),
                .cin  (1'b0),
                .s    (w_s0),
                .cout (w_c0)
            );

            rca_block #(.BLOCK(BLOCK)) u_rca1 (
                .a    (A[k*BLOCK +: BLOCK]),
                .b    (B[k*BLOCK +: BLOCK]),
                .cin  (1'b1),
                .s    (w_s1),
                .cout (w_c1)
            );

            assign w_sum[k*BLOCK +: BLOCK] = w_carry[k] ? w_s1 : w_s0;
            assign w_carry[k+1]            = w_carry[k] ? w_c1 : w_c0;
        end
    end

`ifdef CSA_ADDER3_OUTREG_EN
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    // Reset wins over the in-flight result on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_carry[NBLK];
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
`else
    logic w_unused;

    assign w_unused = clk ^ rst;
    assign S        = w_sum;
    assign Cout     = w_carry[NBLK];
`endif

endmodule

// File: tb/tb_csa_adder3.sv
// Self-checking bench for csa_adder3; follows CSA_ADDER3_OUTREG_EN if defined.
module tb_csa_adder3;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [W-1:0] S;
    logic         Cout;

    int n_cmp;
    int n_bad;
    bit chk_en;

    logic [W:0] exp_q;
    bit         exp_vld;

    csa_adder3 dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {Cout,S}=%h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide addition, with a one-edge delay and reset when registered.
    always @(posedge clk) begin
        if (rst) exp_q <= '0;
        else     exp_q <= {1'b0, A} + {1'b0, B} + (W+1)'(Cin);
        exp_vld <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
`ifdef CSA_ADDER3_OUTREG_EN
            if (exp_vld) check("stream", {Cout, S}, exp_q);
`else
            check("stream", {Cout, S}, {1'b0, A} + {1'b0, B} + (W+1)'(Cin));
`endif
        end
    end

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W:0] exp);
        @(posedge clk);
        #1;
        A   = a;
        B   = b;
        Cin = c;
        @(posedge clk);
        @(negedge clk);
        check(name, {Cout, S}, exp);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        chk_en  = 1'b0;
        exp_vld = 1'b0;
        rst     = 1'b1;
        A       = 32'hFFFF_FFFF;
        B       = 32'hFFFF_FFFF;
        Cin     = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef CSA_ADDER3_OUTREG_EN
        check("reset_hold", {Cout, S}, 33'h0_0000_0000);
`else
        check("reset_hold", {Cout, S}, 33'h1_FFFF_FFFF);
`endif

        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_release", {Cout, S}, 33'h1_FFFF_FFFF);
        chk_en = 1'b1;

        directed("all_ones_plus_one", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
        directed("min_plus_m1_cin",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33'h1_8000_0000);
        directed("five_minus_three",  32'h0000_0005, 32'hFFFF_FFFD, 1'b0, 33'h1_0000_0002);
        directed("seven_plus_ten",    32'h0000_0007, 32'h0000_000A, 1'b0, 33'h0_0000_0011);
        directed("neg4_plus_neg8",    32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b0, 33'h1_FFFF_FFF4);
        directed("zero_plus_cin",     32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001);
        directed("block_chain",       32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 33'h0_1000_0000);
        directed("alt_bits",          32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);

        // Random operands with occasional mid-stream reset pulses.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            A   = pick_operand();
            B   = pick_operand();
            Cin = 1'($urandom);
            rst = ($urandom_range(0, 99) == 0);
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
